lab5_byte_deser: RTL and testbench



---
 rtl/lab5_byte_deser.sv | 124 ++++++++++++
 tb/tb_lab5_byte_deser.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/lab5_byte_deser.sv
// Serial-to-parallel receive stage for the lab5 decoder: 8N1 async frames in,
// registered byte out with one-cycle valid and framing-error strobes.
module lab5_byte_deser #(
  parameter int CLKS_PER_BIT = 4,
  parameter int HALF_BIT     = CLKS_PER_BIT / 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       serial_in,
  output logic [7:0] data_out,
  output logic       data_valid,
  output logic       frame_err,
  output logic       busy
);

  localparam int CYC_W = $clog2(CLKS_PER_BIT);
  localparam logic [CYC_W-1:0] LAST_CYC = CYC_W'(CLKS_PER_BIT - 1);
  localparam logic [CYC_W-1:0] HALF_CYC = CYC_W'(HALF_BIT - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    WAIT_IDLE
  } state_t;

  state_t           r_state;
  logic             r_sync1;
  logic             r_sync2;
  logic [CYC_W-1:0] r_cyc;
  logic [2:0]       r_bitIdx;
  logic [7:0]       r_shift;
  logic             w_rx;

  assign w_rx = r_sync2;
  assign busy = (r_state != IDLE);

  // Two-flop synchronizer; idles high so reset never looks like a start bit.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
    end else begin
      r_sync1 <= serial_in;
      r_sync2 <= r_sync1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= IDLE;
      r_cyc      <= '0;
      r_bitIdx   <= '0;
      r_shift    <= '0;
      data_out   <= 8'h00;
      data_valid <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      data_valid <= 1'b0;
      frame_err  <= 1'b0;
      case (r_state)
        IDLE: begin
          if (!w_rx) begin
            r_state <= START;
            r_cyc   <= '0;
          end
        end
        // A start bit that is gone by mid-bit is treated as a glitch.
        START: begin
          if (r_cyc == HALF_CYC) begin
            r_cyc <= '0;
            if (!w_rx) begin
              r_state  <= DATA;
              r_bitIdx <= '0;
            end else begin
              r_state <= IDLE;
            end
          end else begin
            r_cyc <= r_cyc + 1'b1;
          end
        end
        DATA: begin
          if (r_cyc == LAST_CYC) begin
            r_cyc             <= '0;
            r_shift[r_bitIdx] <= w_rx;
            if (r_bitIdx == 3'd7) begin
              r_state <= STOP;
            end else begin
              r_bitIdx <= r_bitIdx + 1'b1;
            end
          end else begin
            r_cyc <= r_cyc + 1'b1;
          end
        end
        STOP: begin
          if (r_cyc == LAST_CYC) begin
            r_cyc <= '0;
            if (w_rx) begin
              data_out   <= r_shift;
              data_valid <= 1'b1;
              r_state    <= IDLE;
            end else begin
              frame_err <= 1'b1;
              r_state   <= WAIT_IDLE;
            end
          end else begin
            r_cyc <= r_cyc + 1'b1;
          end
        end
        // A stuck-low line must return high before another frame can start.
        WAIT_IDLE: begin
          if (w_rx) begin
            r_state <= IDLE;
          end
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_lab5_byte_deser.sv
// Self-checking bench for lab5_byte_deser: directed frames plus random traffic
// checked each cycle against a frame-level schedule of expected strobes.
module tb_lab5_byte_deser;

  localparam int CPB  = 4;
  localparam int HALF = CPB / 2;
  localparam int LAT  = 2 + HALF + 9 * CPB;

  logic       clk = 1'b0;
  logic       rst;
  logic       serial_in;
  logic [7:0] data_out;
  logic       data_valid;
  logic       frame_err;
  logic       busy;

  typedef struct {
    int         due;
    bit         isErr;
    logic [7:0] data;
  } evt_t;

  evt_t       expQ[$];
  bit         busyExp[int];
  logic [7:0] modelData = 8'h00;
  int         edgeCount = 0;
  int         checks = 0;
  int         errors = 0;
  bit         monEn = 1'b0;
  bit         expV;
  bit         expE;

  lab5_byte_deser #(.CLKS_PER_BIT(CPB)) dut (
    .clk       (clk),
    .rst       (rst),
    .serial_in (serial_in),
    .data_out  (data_out),
    .data_valid(data_valid),
    .frame_err (frame_err),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) edgeCount++;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("[TB] FAIL %s at edge %0d: got %0h expected %0h", tag, edgeCount, obs, exp);
    end
  endtask

  // Per-cycle comparison against the expected event schedule.
  always @(negedge clk) begin
    if (monEn) begin
      expV = 1'b0;
      expE = 1'b0;
      if (expQ.size() > 0 && expQ[0].due == edgeCount) begin
        if (expQ[0].isErr) begin
          expE = 1'b1;
        end else begin
          expV = 1'b1;
          modelData = expQ[0].data;
        end
        void'(expQ.pop_front());
      end
      checkOutput("data_valid", data_valid, expV);
      checkOutput("frame_err", frame_err, expE);
      checkOutput("data_out", data_out, modelData);
      if (busyExp.exists(edgeCount)) checkOutput("busy", busy, busyExp[edgeCount]);
    end
  end

  task automatic driveLevel(input logic b, input int n);
    serial_in = b;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic doReset();
    rst = 1'b1;
    serial_in = 1'b1;
    expQ.delete();
    busyExp.delete();
    @(posedge clk);
    #1;
    modelData = 8'h00;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  // One 8N1 frame; abortBit >= 0 asserts reset partway through that data bit.
  task automatic applyStimulus(input logic [7:0] b, input bit stopBit, input int abortBit);
    int   e0;
    evt_t ev;
    e0 = edgeCount + 1;
    if (abortBit < 0) begin
      ev.due   = e0 + LAT;
      ev.isErr = !stopBit;
      ev.data  = b;
      expQ.push_back(ev);
      for (int e = e0 + 3; e < e0 + LAT; e++) busyExp[e] = 1'b1;
      if (stopBit) busyExp[e0 + LAT] = 1'b0;
    end
    driveLevel(1'b0, CPB);
    for (int i = 0; i < 8; i++) begin
      if (abortBit == i) begin
        driveLevel(b[i], 2);
        doReset();
        return;
      end
      driveLevel(b[i], CPB);
    end
    driveLevel(stopBit, CPB);
  endtask

  initial begin
    int n;
    logic [7:0] rb;
    rst = 1'b1;
    serial_in = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("rst data_out", data_out, 8'h00);
    checkOutput("rst data_valid", data_valid, 1'b0);
    checkOutput("rst frame_err", frame_err, 1'b0);
    checkOutput("rst busy", busy, 1'b0);
    rst = 1'b0;
    monEn = 1'b1;
    for (int e = edgeCount + 1; e <= edgeCount + 50; e++) busyExp[e] = 1'b0;
    driveLevel(1'b1, 50);

    $display("[TB] single frame F0");
    applyStimulus(8'hF0, 1'b1, -1);
    driveLevel(1'b1, 6);

    $display("[TB] back-to-back AA, 55");
    applyStimulus(8'hAA, 1'b1, -1);
    applyStimulus(8'h55, 1'b1, -1);
    driveLevel(1'b1, 6);

    $display("[TB] one-cycle glitch");
    driveLevel(1'b0, 1);
    driveLevel(1'b1, 8);

    $display("[TB] framing error then 81");
    applyStimulus(8'h3C, 1'b0, -1);
    driveLevel(1'b0, 20);
    driveLevel(1'b1, 4);
    applyStimulus(8'h81, 1'b1, -1);
    driveLevel(1'b1, 6);

    $display("[TB] reset mid-frame then C3");
    applyStimulus(8'h0F, 1'b1, 4);
    checkOutput("abort data_out", data_out, 8'h00);
    checkOutput("abort busy", busy, 1'b0);
    driveLevel(1'b1, 4);
    applyStimulus(8'hC3, 1'b1, -1);
    driveLevel(1'b1, 6);

    $display("[TB] random traffic");
    for (int k = 0; k < 20; k++) begin
      rb = 8'($urandom);
      n = int'($urandom_range(0, 5));
      if (n == 0) begin
        driveLevel(1'b0, 1);
        driveLevel(1'b1, 4);
      end
      if (n == 1) begin
        applyStimulus(rb, 1'b0, -1);
        driveLevel(1'b0, int'($urandom_range(0, 10)));
        driveLevel(1'b1, int'($urandom_range(2, 5)));
      end else begin
        applyStimulus(rb, 1'b1, -1);
        driveLevel(1'b1, int'($urandom_range(0, 4)));
      end
    end

    driveLevel(1'b1, LAT + 5);
    checkOutput("pending events", expQ.size(), 0);
    monEn = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
